// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with stall/flush, valid tracking, x0 write
// suppression and a retired-instruction counter. Define LOAD_EXT_EN to align and extend load data.
module mem_wb_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      StallW,
  input  logic                      FlushW,
  input  logic                      ValidM,
  input  logic                      RegWriteM,
  input  logic [1:0]                ResultSrcM,
  input  logic [2:0]                Funct3M,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [DATA_WIDTH-1:0]     RD,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [DATA_WIDTH-1:0]     PC_PlusM,
  output logic                      ValidW,
  output logic                      RegWriteW,
  output logic [1:0]                ResultSrcW,
  output logic [DATA_WIDTH-1:0]     ALUResultW,
  output logic [DATA_WIDTH-1:0]     ReadDataW,
  output logic [REG_ADDR_WIDTH-1:0] RdW,
  output logic [DATA_WIDTH-1:0]     PC_PlusW,
  output logic [CNT_WIDTH-1:0]      RetireCount
);

  logic                      r_valid;
  logic                      r_reg_write;
  logic [1:0]                r_result_src;
  logic [DATA_WIDTH-1:0]     r_alu_result;
  logic [DATA_WIDTH-1:0]     r_read_data;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]     r_pc_plus;
  logic [CNT_WIDTH-1:0]      r_retire_cnt;

  logic [DATA_WIDTH-1:0]     w_read_data;
  logic                      w_reg_write;

`ifdef LOAD_EXT_EN
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lane select by address offset, then RV32I load extension.
  always_comb begin
    case (ALUResultM[1:0])
      2'd0:    w_byte = RD[7:0];
      2'd1:    w_byte = RD[15:8];
      2'd2:    w_byte = RD[23:16];
      default: w_byte = RD[31:24];
    endcase
    w_half = ALUResultM[1] ? RD[31:16] : RD[15:0];
    case (Funct3M)
      3'b000:  w_read_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_read_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_read_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_read_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_read_data = RD;
    endcase
  end
`else
  logic w_unused_funct3;
  assign w_unused_funct3 = ^Funct3M;
  assign w_read_data     = RD;
`endif

  assign w_reg_write = RegWriteM & ValidM & (RdM != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_result_src <= '0;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_rd         <= '0;
      r_pc_plus    <= '0;
      r_retire_cnt <= '0;
    end else if (FlushW) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_result_src <= '0;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_rd         <= '0;
      r_pc_plus    <= '0;
    end else if (!StallW) begin
      r_valid      <= ValidM;
      r_reg_write  <= w_reg_write;
      r_result_src <= ResultSrcM;
      r_alu_result <= ALUResultM;
      r_read_data  <= w_read_data;
      r_rd         <= RdM;
      r_pc_plus    <= PC_PlusM;
      if (ValidM)
        r_retire_cnt <= r_retire_cnt + CNT_WIDTH'(1);
    end
  end

  assign ValidW      = r_valid;
  assign RegWriteW   = r_reg_write;
  assign ResultSrcW  = r_result_src;
  assign ALUResultW  = r_alu_result;
  assign ReadDataW   = r_read_data;
  assign RdW         = r_rd;
  assign PC_PlusW    = r_pc_plus;
  assign RetireCount = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, RD, PC_PlusM;
  logic [4:0]  RdM;

  logic        ValidW, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PC_PlusW, RetireCount;
  logic [4:0]  RdW;

  logic        v4, rw4;
  logic [1:0]  rs4;
  logic [31:0] alu4, rdat4, pc4;
  logic [4:0]  rd4;
  logic [3:0]  cnt4;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .RD(RD), .RdM(RdM),
    .PC_PlusM(PC_PlusM), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .RdW(RdW), .PC_PlusW(PC_PlusW), .RetireCount(RetireCount)
  );

  mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .RD(RD), .RdM(RdM),
    .PC_PlusM(PC_PlusM), .ValidW(v4), .RegWriteW(rw4),
    .ResultSrcW(rs4), .ALUResultW(alu4), .ReadDataW(rdat4),
    .RdW(rd4), .PC_PlusW(pc4), .RetireCount(cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdat, input logic [4:0] rd,
                       input logic [31:0] pc);
    ValidM = v; RegWriteM = rw; ResultSrcM = rs; Funct3M = f3;
    ALUResultM = alu; RD = rdat; RdM = rd; PC_PlusM = pc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ValidW"},      ValidW,      0);
    chk({tag, ".RegWriteW"},   RegWriteW,   0);
    chk({tag, ".ResultSrcW"},  ResultSrcW,  0);
    chk({tag, ".ALUResultW"},  ALUResultW,  0);
    chk({tag, ".ReadDataW"},   ReadDataW,   0);
    chk({tag, ".RdW"},         RdW,         0);
    chk({tag, ".PC_PlusW"},    PC_PlusW,    0);
  endtask

  logic [31:0] exp_ld [4];
  logic [2:0]  ld_f3  [4];
  logic [1:0]  ld_off [4];

  initial begin
    ld_f3[0] = 3'b000; ld_off[0] = 2'd3;
    ld_f3[1] = 3'b100; ld_off[1] = 2'd1;
    ld_f3[2] = 3'b001; ld_off[2] = 2'd2;
    ld_f3[3] = 3'b101; ld_off[3] = 2'd0;
`ifdef LOAD_EXT_EN
    exp_ld[0] = 32'hFFFF_FF80; exp_ld[1] = 32'h0000_007F;
    exp_ld[2] = 32'hFFFF_80FF; exp_ld[3] = 32'h0000_7F01;
`else
    exp_ld[0] = 32'h80FF_7F01; exp_ld[1] = 32'h80FF_7F01;
    exp_ld[2] = 32'h80FF_7F01; exp_ld[3] = 32'h80FF_7F01;
`endif

    // Reset held two edges with busy inputs
    rst_n = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    drive(1, 1, 2'b01, 3'b010, 32'h1234, 32'hDEAD_BEEF, 5'd7, 32'h88);
    step(); step();
    chk_zero("reset");
    chk("reset.RetireCount", RetireCount, 0);
    chk("reset.cnt4", cnt4, 0);

    // First capture on the edge after release
    rst_n = 1'b1;
    drive(1, 1, 2'b01, 3'b010, 32'h1000, 32'h80FF_7F01, 5'd5, 32'h44);
    step();
    chk("cap.ValidW", ValidW, 1);
    chk("cap.RegWriteW", RegWriteW, 1);
    chk("cap.RdW", RdW, 5);
    chk("cap.ALUResultW", ALUResultW, 32'h1000);
    chk("cap.PC_PlusW", PC_PlusW, 32'h44);
    chk("cap.ResultSrcW", ResultSrcW, 2'b01);
    chk("cap.ReadDataW", ReadDataW, 32'h80FF_7F01);
    chk("cap.RetireCount", RetireCount, 1);

    // Write to x0 suppressed, still retires
    drive(1, 1, 2'b00, 3'b010, 32'h2000, 32'h0, 5'd0, 32'h48);
    step();
    chk("x0.RegWriteW", RegWriteW, 0);
    chk("x0.ValidW", ValidW, 1);
    chk("x0.RetireCount", RetireCount, 2);

    // Invalid slot: no write, no retire
    drive(0, 1, 2'b00, 3'b010, 32'h3000, 32'h0, 5'd3, 32'h4C);
    step();
    chk("inv.RegWriteW", RegWriteW, 0);
    chk("inv.ValidW", ValidW, 0);
    chk("inv.RdW", RdW, 3);
    chk("inv.RetireCount", RetireCount, 2);

    // ResultSrc 11 passes through untouched
    drive(1, 1, 2'b11, 3'b010, 32'hABCD, 32'h5555_AAAA, 5'd9, 32'h50);
    step();
    chk("rs11.ResultSrcW", ResultSrcW, 2'b11);
    chk("rs11.RegWriteW", RegWriteW, 1);
    chk("rs11.RetireCount", RetireCount, 3);

    // Three-cycle stall with changing inputs
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b01, 3'b000, 32'h7000 + i, 32'h1111_0000 + i, 5'd20 + 5'(i), 32'h900 + i);
      step();
      chk("stall.ALUResultW", ALUResultW, 32'hABCD);
      chk("stall.RdW", RdW, 9);
      chk("stall.ReadDataW", ReadDataW, 32'h5555_AAAA);
      chk("stall.RetireCount", RetireCount, 3);
    end

    // Flush wins over simultaneous stall; counter untouched
    FlushW = 1'b1;
    step();
    chk_zero("flush");
    chk("flush.RetireCount", RetireCount, 3);
    StallW = 1'b0; FlushW = 1'b0;

    // Load formatting at various offsets
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2'b01, ld_f3[i], {30'h400, ld_off[i]}, 32'h80FF_7F01, 5'd10, 32'h60);
      step();
      chk("load.ReadDataW", ReadDataW, exp_ld[i]);
      chk("load.RetireCount", RetireCount, 4 + i);
    end

    // Reset mid-stream discards the W entry
    drive(1, 1, 2'b10, 3'b010, 32'h8000, 32'h1, 5'd12, 32'h70);
    rst_n = 1'b0;
    step();
    chk_zero("midrst");
    chk("midrst.RetireCount", RetireCount, 0);
    chk("midrst.cnt4", cnt4, 0);
    rst_n = 1'b1;
    step();
    chk("postrst.PC_PlusW", PC_PlusW, 32'h70);
    chk("postrst.ResultSrcW", ResultSrcW, 2'b10);
    chk("postrst.RetireCount", RetireCount, 1);
    chk("postrst.cnt4", cnt4, 1);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 14; i++) begin
      drive(1, 1, 2'b00, 3'b010, 32'(i), 32'h0, 5'd1, 32'h0);
      step();
    end
    chk("wrap.cnt4_pre", cnt4, 15);
    chk("wrap.cnt32_pre", RetireCount, 15);
    step(); step();
    chk("wrap.cnt4", cnt4, 1);
    chk("wrap.cnt32", RetireCount, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
